// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared types, widths and helpers for the MULT32 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int WORD_W      = 32;
    localparam int LATENCY_MAX = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Unsigned magnitude of an operand; 0x80000000 maps onto itself.
    function automatic logic [WORD_W-1:0] operand_mag(input logic            is_signed,
                                                      input logic [WORD_W-1:0] value);
        return (is_signed && value[WORD_W-1]) ? (~value + WORD_W'(1)) : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_sign_fix.sv
// ============================================================================
// Module      : mult_sign_fix
// Description : Conditional two's-complement negate of the full product word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_sign_fix #(
    parameter int W = 64
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_value
);

    // One wide add so the +1 carry ripples from the LO half into the HI half.
    assign o_value = i_neg ? (~i_value + W'(1)) : i_value;

endmodule

`default_nettype wire

// File: rtl/mult_ctrl.sv
// ============================================================================
// Module      : mult_ctrl
// Description : Sequences one MULT32 multiply, applies sign correction and
//               commits the product into HI/LO; also handles MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_ctrl
    import mult_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [WORD_W-1:0] i_op_a,
    input  logic [WORD_W-1:0] i_op_b,
    input  logic              i_mthi,
    input  logic              i_mtlo,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [WORD_W-1:0] o_hi,
    output logic [WORD_W-1:0] o_lo,
    output logic [WORD_W-1:0] o_mul_a,
    output logic [WORD_W-1:0] o_mul_b,
    input  logic [WORD_W-1:0] i_mul_hi,
    input  logic [WORD_W-1:0] i_mul_lo
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_latency_check
            $error("mult_ctrl: LATENCY must be within 1..LATENCY_MAX");
        end
    endgenerate

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_neg;
    logic                r_busy;
    logic                r_done;
    logic [WORD_W-1:0]   r_hi;
    logic [WORD_W-1:0]   r_lo;
    logic [WORD_W-1:0]   r_mul_a;
    logic [WORD_W-1:0]   r_mul_b;
    logic [2*WORD_W-1:0] w_product;

    mult_sign_fix #(
        .W (2*WORD_W)
    ) u_sign_fix (
        .i_neg   (r_neg),
        .i_value ({i_mul_hi, i_mul_lo}),
        .o_value (w_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A START in the same cycle as an MT write drops the write.
                    if (i_start) begin
                        r_mul_a <= operand_mag(i_signed, i_op_a);
                        r_mul_b <= operand_mag(i_signed, i_op_b);
                        r_neg   <= i_signed & (i_op_a[WORD_W-1] ^ i_op_b[WORD_W-1]);
                        r_cnt   <= c_cnt_load;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        if (i_mthi) r_hi <= i_wdata;
                        if (i_mtlo) r_lo <= i_wdata;
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_product;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_mul_a = r_mul_a;
    assign o_mul_b = r_mul_b;

endmodule

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
// ============================================================================
// Module      : tb_mult_ctrl
// Description : Self-checking bench for mult_ctrl with a behavioural MULT32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    int checks = 0;
    int errors = 0;

    // Combinational MULT32 stand-in.
    assign {mul_hi, mul_lo} = {32'b0, mul_a} * {32'b0, mul_b};

    mult_ctrl #(.LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .i_signed (sgn),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_mthi   (mthi),
        .i_mtlo   (mtlo),
        .i_wdata  (wdata),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_mul_a  (mul_a),
        .o_mul_b  (mul_b),
        .i_mul_hi (mul_hi),
        .i_mul_lo (mul_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Drives one request and records BUSY/DONE behaviour after the accepting edge.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output int busy_cnt, output int done_cnt, output int done_at);
        @(negedge clk);
        start = 1'b1; sgn = s; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < LAT + 4; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, hi, lo, mul_a, mul_b} !== {2'b00, 128'h0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h a=%h b=%h required all zero",
                     busy, done, hi, lo, mul_a, mul_b);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        logic [31:0] vb [5] = '{32'd10, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'hFFFF_FFFB};
        logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] ve [5] = '{64'h0000_0000_0000_0028, 64'hFFFF_FFFE_0000_0001,
                                64'hFFFF_FFFF_FFFF_FFFD, 64'h4000_0000_0000_0000, 64'h0};
        logic [31:0] ma [5] = '{32'd4, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd0};
        logic [31:0] mb [5] = '{32'd10, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd5};
        int bc, dc, da;
        for (int i = 0; i < 5; i++) begin
            run_mult(va[i], vb[i], vs[i], bc, dc, da);
            checks++;
            if ({hi, lo} !== ve[i]) begin
                errors++;
                $display("FAIL directed[%0d] hilo got %h required %h", i, {hi, lo}, ve[i]);
            end
            checks++;
            if ({mul_a, mul_b} !== {ma[i], mb[i]}) begin
                errors++;
                $display("FAIL directed[%0d] magnitudes got %h %h required %h %h",
                         i, mul_a, mul_b, ma[i], mb[i]);
            end
            checks++;
            if (bc !== LAT || dc !== 1 || da !== LAT) begin
                errors++;
                $display("FAIL directed[%0d] timing got busy=%0d done=%0d at %0d required %0d 1 at %0d",
                         i, bc, dc, da, LAT, LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        logic [63:0] exp;
        int bc, dc, da;
        for (int i = 0; i < 24; i++) begin
            a = (i % 4 == 3) ? 32'h8000_0000 : $urandom;
            b = (i % 5 == 4) ? 32'd0 : $urandom;
            s = 1'($urandom_range(0, 1));
            exp = ref_prod(a, b, s);
            run_mult(a, b, s, bc, dc, da);
            checks++;
            if ({hi, lo} !== exp || dc !== 1 || da !== LAT) begin
                errors++;
                $display("FAIL random[%0d] %h*%h s=%b got %h done=%0d at %0d required %h 1 at %0d",
                         i, a, b, s, {hi, lo}, dc, da, exp, LAT);
            end
        end
    endtask

    task automatic test_start_in_run();
        int dc;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; op_a = 32'd15; op_b = 32'd7;
        @(posedge clk); #1;
        op_a = 32'd7; op_b = 32'd7; mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        dc = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (done === 1'b1) dc++;
            @(posedge clk); #1;
        end
        checks++;
        if (dc !== 1 || hi !== 32'h0 || lo !== 32'd105) begin
            errors++;
            $display("FAIL start_in_run got done=%0d hi=%h lo=%0d required 1 0 105", dc, hi, lo);
        end
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234;
        #1;
        checks++;
        if (hi !== 32'h0) begin
            errors++;
            $display("FAIL mthi_bypass got hi=%h required 00000000 before edge", hi);
        end
        @(posedge clk); #1;
        mthi = 1'b0;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'd105) begin
            errors++;
            $display("FAIL mthi_write got hi=%h lo=%0d required 00001234 105", hi, lo);
        end
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_0F0F || lo !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL mt_both got hi=%h lo=%h required a5a50f0f a5a50f0f", hi, lo);
        end
    endtask

    task automatic test_start_with_mt();
        int cyc;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; op_a = 32'd2; op_b = 32'd3;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (busy !== 1'b1 || lo !== 32'hA5A5_0F0F || hi !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL start_wins got busy=%b hi=%h lo=%h required 1 a5a50f0f a5a50f0f",
                     busy, hi, lo);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < LAT + 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== LAT || hi !== 32'h0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL start_wins_result got cyc=%0d hi=%h lo=%0d required %0d 0 6", cyc, hi, lo, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [63:0] exp;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            a[i] = $urandom | 32'h1;
            b[i] = $urandom | 32'h1;
        end
        @(negedge clk);
        start = 1'b1; sgn = 1'b1; op_a = a[0]; op_b = b[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            while (done !== 1'b1 && cyc < LAT + 8) begin
                @(posedge clk); #1;
                cyc++;
            end
            exp = ref_prod(a[i], b[i], 1'b1);
            checks++;
            if (cyc !== LAT || {hi, lo} !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d] got cyc=%0d hilo=%h required %0d %h",
                         i, cyc, {hi, lo}, LAT, exp);
            end
            if (i < 3) begin
                // Issue the next request in the DONE cycle.
                start = 1'b1; op_a = a[i+1]; op_b = b[i+1];
                @(posedge clk); #1;
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL back_to_back_accept[%0d] got busy=%b required 1", i + 1, busy);
                end
            end
        end
    endtask

    task automatic test_rst_mid_run();
        int dc, bc, da;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; op_a = 32'd8; op_b = 32'd8;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_run got busy=%b done=%b hi=%h lo=%h required 0 0 0 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dc++;
        end
        checks++;
        if (dc !== 0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL rst_no_done got activity=%0d lo=%h required 0 0", dc, lo);
        end
        run_mult(32'd2, 32'd0, 1'b0, bc, dc, da);
        checks++;
        if (dc !== 1 || hi !== 32'h0 || lo !== 32'h0 || bc !== LAT) begin
            errors++;
            $display("FAIL rst_fresh got done=%0d busy=%0d hi=%h lo=%h required 1 %0d 0 0",
                     dc, bc, hi, lo, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_start_with_mt();
        test_back_to_back();
        test_rst_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
